joystick_filter: RTL and testbench

Downstream consumer of the XADC joystick interface's four 12-bit unipolar axis readings (two analog joysticks, X/Y each). Decimates the free-running ADC values at a fixed sample rate, self-calibrates each axis centre after reset or on request, box-filters samples, and applies a dead zone. Emits clamped signed per-axis velocities with a one-cycle update strobe, consumed by the sprite-movement logic.

---
 rtl/joystick_pkg.sv | 20 ++
 rtl/joystick_axis.sv | 98 +++++++++
 rtl/joystick_filter.sv | 133 +++++++++++++
 tb/tb_joystick_filter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/joystick_pkg.sv
// Shared types and constants for the dual-joystick velocity filter.
package joystick_pkg;

  typedef enum logic {
    CAL,
    RUN
  } state_t;

  localparam int N_AXES  = 4;
  localparam int ADC_W   = 12;
  localparam int VEL_W   = 5;
  localparam int VEL_MAX = 15;

  localparam logic [ADC_W-1:0] CENTER_RESET = 12'd2048;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joystick_axis.sv
// One joystick axis: sample accumulator, calibrated centre, dead zone,
// scaling and clamping into a registered signed velocity.
module joystick_axis
  import joystick_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int CAL_LOG2  = 4,
  parameter int DEADZONE  = 200,
  parameter int VEL_SHIFT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc,
  input  logic             sample_en,
  input  logic             acc_clear,
  input  logic             cal_load,
  input  logic             vel_load,
  input  logic             vel_clear,
  output logic [VEL_W-1:0] vel
);

  localparam int ACC_W = ADC_W + max_int(AVG_LOG2, CAL_LOG2);
  localparam int OFF_W = ADC_W + 2;

  localparam logic signed [OFF_W-1:0] DZ     = OFF_W'(DEADZONE);
  localparam logic signed [OFF_W-1:0] NDZ    = -DZ;
  localparam logic signed [OFF_W-1:0] VMAX   = OFF_W'(VEL_MAX);
  localparam logic signed [OFF_W-1:0] NVMAX  = -VMAX;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] cal_sum;
  logic [ACC_W-1:0] avg_sum;
  logic [ADC_W-1:0] center;
  logic [ADC_W-1:0] filt;

  logic signed [OFF_W-1:0] off;
  logic signed [OFF_W-1:0] adj;
  logic signed [OFF_W-1:0] shifted;
  logic        [VEL_W-1:0] vel_next;

  // The block-completing sample is folded in combinationally so the
  // centre/velocity update lands on the same edge as that sample.
  assign sum     = acc + ACC_W'(adc);
  assign cal_sum = sum >> CAL_LOG2;
  assign avg_sum = sum >> AVG_LOG2;
  assign filt    = avg_sum[ADC_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (sample_en) begin
      acc <= sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      center <= CENTER_RESET;
    end else if (cal_load) begin
      center <= cal_sum[ADC_W-1:0];
    end
  end

  // Offset outside the dead zone is pulled toward zero by DEADZONE so the
  // velocity ramps from 0 at the zone edge, then floor-shifted and clamped.
  always_comb begin
    off      = $signed({2'b00, filt}) - $signed({2'b00, center});
    adj      = '0;
    vel_next = '0;
    if (off > DZ) begin
      adj = off - DZ;
    end else if (off < NDZ) begin
      adj = off + DZ;
    end
    shifted = adj >>> VEL_SHIFT;
    if (shifted > VMAX) begin
      vel_next = VMAX[VEL_W-1:0];
    end else if (shifted < NVMAX) begin
      vel_next = NVMAX[VEL_W-1:0];
    end else begin
      vel_next = shifted[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vel <= '0;
    end else if (vel_clear) begin
      vel <= '0;
    end else if (vel_load) begin
      vel <= vel_next;
    end
  end

endmodule

// File: rtl/joystick_filter.sv
// Decimates four joystick ADC channels, self-calibrates their centres and
// emits dead-zoned, clamped signed velocities with an update strobe.
module joystick_filter
  import joystick_pkg::*;
#(
  parameter int SAMPLE_DIV = 100_000,
  parameter int AVG_LOG2   = 3,
  parameter int CAL_LOG2   = 4,
  parameter int DEADZONE   = 200,
  parameter int VEL_SHIFT  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc0_in,
  input  logic [ADC_W-1:0] adc1_in,
  input  logic [ADC_W-1:0] adc2_in,
  input  logic [ADC_W-1:0] adc3_in,
  input  logic             recal,
  output logic [VEL_W-1:0] vel0,
  output logic [VEL_W-1:0] vel1,
  output logic [VEL_W-1:0] vel2,
  output logic [VEL_W-1:0] vel3,
  output logic             vel_valid,
  output logic             cal_done
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = max_int(max_int(AVG_LOG2, CAL_LOG2), 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t state;
  state_t state_next;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic             tick;
  logic             sample;
  logic             cal_end;
  logic             blk_end;

  logic [ADC_W-1:0] adc_arr [N_AXES];
  logic [VEL_W-1:0] vel_arr [N_AXES];

  // recal outranks a coincident tick, so its sample never reaches the axes.
  assign tick    = (div_cnt == DIV_LAST);
  assign sample  = tick && !recal;
  assign cal_end = sample && (state == CAL) && (sample_cnt == CAL_LAST);
  assign blk_end = sample && (state == RUN) && (sample_cnt == AVG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (recal || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (recal) begin
      sample_cnt <= '0;
    end else if (sample) begin
      if (cal_end || blk_end) begin
        sample_cnt <= '0;
      end else begin
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (recal) begin
      state_next = CAL;
    end else if (state == CAL && cal_end) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= blk_end;
    end
  end

  assign cal_done = (state == RUN);

  assign adc_arr[0] = adc0_in;
  assign adc_arr[1] = adc1_in;
  assign adc_arr[2] = adc2_in;
  assign adc_arr[3] = adc3_in;

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    joystick_axis #(
      .AVG_LOG2  (AVG_LOG2),
      .CAL_LOG2  (CAL_LOG2),
      .DEADZONE  (DEADZONE),
      .VEL_SHIFT (VEL_SHIFT)
    ) u_axis (
      .clk       (clk),
      .reset     (reset),
      .adc       (adc_arr[i]),
      .sample_en (sample),
      .acc_clear (recal || cal_end || blk_end),
      .cal_load  (cal_end),
      .vel_load  (blk_end),
      .vel_clear (recal),
      .vel       (vel_arr[i])
    );
  end

  assign vel0 = vel_arr[0];
  assign vel1 = vel_arr[1];
  assign vel2 = vel_arr[2];
  assign vel3 = vel_arr[3];

endmodule

// File: tb/tb_joystick_filter.sv
// Scoreboard bench for joystick_filter: each block's expected velocities are
// queued when its inputs are applied and popped on every vel_valid.
module tb_joystick_filter;

  logic        clk;
  logic        reset;
  logic [11:0] adc0_in, adc1_in, adc2_in, adc3_in;
  logic        recal;
  logic [4:0]  vel0, vel1, vel2, vel3;
  logic        vel_valid;
  logic        cal_done;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  joystick_filter #(
    .SAMPLE_DIV (4),
    .AVG_LOG2   (2),
    .CAL_LOG2   (2),
    .DEADZONE   (200),
    .VEL_SHIFT  (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adc0_in   (adc0_in),
    .adc1_in   (adc1_in),
    .adc2_in   (adc2_in),
    .adc3_in   (adc3_in),
    .recal     (recal),
    .vel0      (vel0),
    .vel1      (vel1),
    .vel2      (vel2),
    .vel3      (vel3),
    .vel_valid (vel_valid),
    .cal_done  (cal_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every strobe must come from RUN and match the queued block.
  always @(negedge clk) begin
    logic [19:0] e;
    if (vel_valid) begin
      checks++;
      if (!cal_done) begin
        errors++;
        $display("[TB] FAIL valid_in_cal: cal_done=%0d required 1", cal_done);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: got vel=%0d,%0d,%0d,%0d with no expectation",
                 $signed(vel0), $signed(vel1), $signed(vel2), $signed(vel3));
      end else begin
        e = exp_q.pop_front();
        if ({vel0, vel1, vel2, vel3} !== e) begin
          errors++;
          $display("[TB] FAIL vel_block: got %0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d",
                   $signed(vel0), $signed(vel1), $signed(vel2), $signed(vel3),
                   $signed(e[19:15]), $signed(e[14:10]), $signed(e[9:5]), $signed(e[4:0]));
        end
      end
    end
  end

  task automatic check_output(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic push_exp(input int v0, input int v1, input int v2, input int v3);
    exp_q.push_back({5'(v0), 5'(v1), 5'(v2), 5'(v3)});
  endtask

  task automatic wait_valid(output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (vel_valid) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_valid: got no vel_valid in %0d cycles required one", n);
    end
  endtask

  task automatic set_inputs(input logic [11:0] a0, input logic [11:0] a1,
                            input logic [11:0] a2, input logic [11:0] a3);
    adc0_in = a0;
    adc1_in = a1;
    adc2_in = a2;
    adc3_in = a3;
  endtask

  // Wait for the current block to end, then hold new inputs for the next one.
  task automatic apply_stimulus(input logic [11:0] a0, input logic [11:0] a1,
                                input logic [11:0] a2, input logic [11:0] a3,
                                input int v0, input int v1, input int v2, input int v3,
                                output int waited);
    wait_valid(waited);
    #1;
    set_inputs(a0, a1, a2, a3);
    push_exp(v0, v1, v2, v3);
  endtask

  task automatic apply_alternating();
    int n;
    wait_valid(n);
    #1;
    push_exp(6, 0, 0, 0);
    set_inputs(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    for (int i = 0; i < 4; i++) begin
      adc0_in = (i % 2 == 0) ? 12'd2048 : 12'd4095;
      if (i < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic recal_and_cal(input logic [11:0] c0, input logic [11:0] c1,
                               input logic [11:0] c2, input logic [11:0] c3,
                               input bit on_tick);
    int n;
    bit bad;
    wait_valid(n);
    #1;
    if (on_tick) begin
      set_inputs(12'd1000, 12'd1000, 12'd1000, 12'd1000);
      repeat (3) @(negedge clk);
    end else begin
      set_inputs(c0, c1, c2, c3);
      repeat (5) @(negedge clk);
    end
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    set_inputs(c0, c1, c2, c3);
    check_output("recal_cal_done_drop", cal_done, 0);
    check_output("recal_vel_zero", int'({vel0, vel1, vel2, vel3}), 0);
    check_output("recal_no_valid", vel_valid, 0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (cal_done || vel_valid) bad = 1;
    end
    check_output("recal_cal_hold", bad, 0);
    @(negedge clk);
    check_output("recal_cal_done_rise", cal_done, 1);
    push_exp(0, 0, 0, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    recal = 1'b0;
    set_inputs(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    repeat (2) @(negedge clk);
    check_output("reset_vel", int'({vel0, vel1, vel2, vel3}), 0);
    check_output("reset_valid", vel_valid, 0);
    check_output("reset_cal_done", cal_done, 0);
    reset = 1'b0;

    repeat (15) @(posedge clk);
    @(negedge clk);
    check_output("cal_done_cycle16", cal_done, 0);
    @(posedge clk);
    @(negedge clk);
    check_output("cal_done_cycle17", cal_done, 1);
    push_exp(0, 0, 0, 0);

    apply_stimulus(12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 0, 0, n);
    check_output("first_block_latency", n, 16);
    apply_stimulus(12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 0, 0, n);
    check_output("update_period", n, 16);

    apply_stimulus(12'd4095, 12'd0, 12'd2048, 12'd2048, 14, -15, 0, 0, n);
    apply_stimulus(12'd2048, 12'd2048, 12'd2248, 12'd2048, 0, 0, 0, 0, n);
    apply_stimulus(12'd2048, 12'd2048, 12'd2249, 12'd2048, 0, 0, 0, 0, n);
    apply_stimulus(12'd2048, 12'd2048, 12'd2376, 12'd2048, 0, 0, 1, 0, n);
    apply_stimulus(12'd2048, 12'd2048, 12'd1720, 12'd2048, 0, 0, -1, 0, n);
    apply_alternating();

    recal_and_cal(12'd3000, 12'd3000, 12'd3000, 12'd3000, 1'b0);
    apply_stimulus(12'd3000, 12'd3000, 12'd3000, 12'd3000, 0, 0, 0, 0, n);
    apply_stimulus(12'd3328, 12'd3000, 12'd3000, 12'd3000, 1, 0, 0, 0, n);

    recal_and_cal(12'd2048, 12'd2048, 12'd2048, 12'd0, 1'b1);
    apply_stimulus(12'd2376, 12'd2048, 12'd2048, 12'd0, 1, 0, 0, 0, n);
    apply_stimulus(12'd2048, 12'd2048, 12'd2048, 12'd4095, 0, 0, 0, 15, n);

    wait_valid(n);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_vel", int'({vel0, vel1, vel2, vel3}), 0);
    check_output("async_reset_valid", vel_valid, 0);
    check_output("async_reset_cal_done", cal_done, 0);
    check_output("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
